// File: rtl/gate_sweep_ctrl.sv
// Truth-table sweep controller for the custom gate F = !C && (!A || B).
// Drives all eight {A,B,C} vectors, captures F per vector and scores the table.

module gate_sweep_ctrl #(
    parameter logic [3:0] SETTLE = 4'd1,
    parameter logic [7:0] EXPECT = 8'h45
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       ABORT,
    input  logic       F_IN,
    output logic       A_OUT,
    output logic       B_OUT,
    output logic       C_OUT,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [7:0] TABLE,
    output logic [3:0] MISMATCH_CNT,
    output logic [2:0] FAIL_IDX
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] vec_q, vec_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [7:0] table_q, table_d;
    logic [3:0] mcnt_q, mcnt_d;
    logic [2:0] fidx_q, fidx_d;
    logic       miss;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        table_d = table_q;
        mcnt_d  = mcnt_q;
        fidx_d  = fidx_q;
        miss    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (START && !ABORT) begin
                    state_d = S_RUN;
                    idx_d   = 3'd0;
                    cnt_d   = SETTLE;
                    table_d = 8'd0;
                    mcnt_d  = 4'd0;
                    fidx_d  = 3'd0;
                    pass_d  = 1'b0;
                end
            end
            S_RUN: begin
                if (ABORT) begin
                    // Partial results are kept for diagnosis; PASS stays clear.
                    state_d = S_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    table_d[idx_q] = F_IN;
                    miss = (F_IN != EXPECT[idx_q]);
                    if (miss) begin
                        mcnt_d = mcnt_q + 4'd1;
                        if (mcnt_q == 4'd0) begin
                            fidx_d = idx_q;
                        end
                    end
                    if (idx_q != 3'd7) begin
                        idx_d = idx_q + 3'd1;
                        cnt_d = SETTLE;
                    end else begin
                        // Verdict includes the compare of the final vector.
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        pass_d  = (mcnt_d == 4'd0);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        vec_d = (state_d == S_RUN) ? idx_d : 3'd0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            vec_q   <= 3'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            table_q <= 8'd0;
            mcnt_q  <= 4'd0;
            fidx_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            table_q <= table_d;
            mcnt_q  <= mcnt_d;
            fidx_q  <= fidx_d;
        end
    end

    assign {A_OUT, B_OUT, C_OUT} = vec_q;
    assign BUSY         = (state_q == S_RUN);
    assign DONE         = done_q;
    assign PASS         = pass_q;
    assign TABLE        = table_q;
    assign MISMATCH_CNT = mcnt_q;
    assign FAIL_IDX     = fidx_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: one instance at SETTLE=1, one at SETTLE=0, each fed
// by a lookup-table gate model, scored against a truth-table reference model.

module tb_gate_sweep_ctrl;

    localparam logic [7:0] EXP = 8'h45;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start1, abort1, a1, b1, c1, busy1, done1, pass1, f1;
    logic [7:0] tab1, ftab1;
    logic [3:0] mc1;
    logic [2:0] fi1;

    logic       start0, abort0, a0, b0, c0, busy0, done0, pass0, f0;
    logic [7:0] tab0, ftab0;
    logic [3:0] mc0;
    logic [2:0] fi0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign f1 = ftab1[{a1, b1, c1}];
    assign f0 = ftab0[{a0, b0, c0}];

    gate_sweep_ctrl #(.SETTLE(4'd1), .EXPECT(EXP)) dut1 (
        .CLK(clk), .RST_N(rst_n), .START(start1), .ABORT(abort1), .F_IN(f1),
        .A_OUT(a1), .B_OUT(b1), .C_OUT(c1), .BUSY(busy1), .DONE(done1), .PASS(pass1),
        .TABLE(tab1), .MISMATCH_CNT(mc1), .FAIL_IDX(fi1)
    );

    gate_sweep_ctrl #(.SETTLE(4'd0), .EXPECT(EXP)) dut0 (
        .CLK(clk), .RST_N(rst_n), .START(start0), .ABORT(abort0), .F_IN(f0),
        .A_OUT(a0), .B_OUT(b0), .C_OUT(c0), .BUSY(busy0), .DONE(done0), .PASS(pass0),
        .TABLE(tab0), .MISMATCH_CNT(mc0), .FAIL_IDX(fi0)
    );

    function automatic logic [7:0] gate_truth();
        logic [7:0] t;
        logic a, b, c;
        t = 8'd0;
        for (int k = 0; k < 8; k++) begin
            a = k[2];
            b = k[1];
            c = k[0];
            t[k] = !c && (!a || b);
        end
        return t;
    endfunction

    function automatic logic [7:0] not_c_truth();
        logic [7:0] t;
        t = 8'd0;
        for (int k = 0; k < 8; k++) t[k] = !k[0];
        return t;
    endfunction

    // Reference: first ncap vectors are captured; score them against EXP.
    task automatic model(input logic [7:0] ft, input int ncap,
                         output logic [7:0] tab, output int cnt, output logic [2:0] fidx);
        logic [7:0] ev;
        ev   = EXP;
        tab  = 8'd0;
        cnt  = 0;
        fidx = 3'd0;
        for (int k = 0; k < ncap; k++) begin
            tab[k] = ft[k];
            if (ft[k] != ev[k]) begin
                if (cnt == 0) fidx = 3'(k);
                cnt++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; ftab1 = 8'd0;
        start0 = 1'b0; abort0 = 1'b0; ftab0 = 8'd0;
        tick(); tick(); tick();
        checks++;
        if ({a1, b1, c1, busy1, done1, pass1, tab1, mc1, fi1} !== 21'd0) begin
            errors++;
            $display("FAIL reset_dut1 got %h want 0", {a1, b1, c1, busy1, done1, pass1, tab1, mc1, fi1});
        end
        checks++;
        if ({a0, b0, c0, busy0, done0, pass0, tab0, mc0, fi0} !== 21'd0) begin
            errors++;
            $display("FAIL reset_dut0 got %h want 0", {a0, b0, c0, busy0, done0, pass0, tab0, mc0, fi0});
        end
        #3 rst_n = 1'b1;
        tick(); tick();
        checks++;
        if ({busy1, done1, a1, b1, c1} !== 5'd0) begin
            errors++;
            $display("FAIL idle_after_reset got %b want 00000", {busy1, done1, a1, b1, c1});
        end
    endtask

    // Full single-START sweep on the SETTLE=1 instance with timing checks.
    task automatic sweep1(input logic [7:0] ft, input string nm);
        logic [7:0] et;
        int         ec;
        logic [2:0] ei;
        logic [4:0] want;
        ftab1 = ft;
        model(ft, 8, et, ec, ei);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int n = 0; n < 16; n++) begin
            want = {1'b1, 1'b0, 3'(n / 2)};
            checks++;
            if ({busy1, done1, a1, b1, c1} !== want) begin
                errors++;
                $display("FAIL %s busy_done_vec cycle %0d got %b want %b", nm, n, {busy1, done1, a1, b1, c1}, want);
            end
            tick();
        end
        checks++;
        if ({busy1, done1, a1, b1, c1} !== 5'b01000) begin
            errors++;
            $display("FAIL %s done_cycle got %b want 01000", nm, {busy1, done1, a1, b1, c1});
        end
        checks++;
        if (tab1 !== et) begin
            errors++;
            $display("FAIL %s table got %h want %h", nm, tab1, et);
        end
        checks++;
        if (mc1 !== 4'(ec)) begin
            errors++;
            $display("FAIL %s mismatch_cnt got %0d want %0d", nm, mc1, ec);
        end
        checks++;
        if (fi1 !== ei) begin
            errors++;
            $display("FAIL %s fail_idx got %0d want %0d", nm, fi1, ei);
        end
        checks++;
        if (pass1 !== (ec == 0)) begin
            errors++;
            $display("FAIL %s pass got %b want %b", nm, pass1, (ec == 0));
        end
        tick();
        checks++;
        if ({done1, busy1, tab1, pass1} !== {2'b00, et, (ec == 0)}) begin
            errors++;
            $display("FAIL %s hold_after_done got %h want %h", nm, {done1, busy1, tab1, pass1}, {2'b00, et, (ec == 0)});
        end
    endtask

    // ABORT raised during cycle c; vector k is captured at the edge ending cycle 2k+1.
    task automatic test_abort(input int c, input logic [7:0] ft, input string nm);
        logic [7:0] et;
        int         ec;
        logic [2:0] ei;
        ftab1 = ft;
        model(ft, c / 2, et, ec, ei);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < c; i++) tick();
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        checks++;
        if ({busy1, done1, pass1, a1, b1, c1} !== 6'd0) begin
            errors++;
            $display("FAIL %s after_abort got %b want 000000", nm, {busy1, done1, pass1, a1, b1, c1});
        end
        checks++;
        if ({tab1, mc1, fi1} !== {et, 4'(ec), ei}) begin
            errors++;
            $display("FAIL %s partial got %h want %h", nm, {tab1, mc1, fi1}, {et, 4'(ec), ei});
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({busy1, done1, pass1, tab1} !== {3'b000, et}) begin
                errors++;
                $display("FAIL %s post_abort_quiet got %h want %h", nm, {busy1, done1, pass1, tab1}, {3'b000, et});
            end
        end
    endtask

    // SETTLE=0 instance: START+ABORT blocked, then START held for repeating runs.
    task automatic test_back_to_back();
        logic [7:0] et;
        int         ec;
        logic [2:0] ei;
        int         ph;
        logic [4:0] want;
        ftab0  = gate_truth();
        start0 = 1'b1;
        abort0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({busy0, a0, b0, c0} !== 4'd0) begin
                errors++;
                $display("FAIL start_abort_idle got %b want 0000", {busy0, a0, b0, c0});
            end
        end
        abort0 = 1'b0;
        tick();
        for (int n = 0; n < 36; n++) begin
            ph   = n % 9;
            want = (ph < 8) ? {1'b1, 1'b0, 3'(ph)} : 5'b01000;
            checks++;
            if ({busy0, done0, a0, b0, c0} !== want) begin
                errors++;
                $display("FAIL b2b busy_done_vec cycle %0d got %b want %b", n, {busy0, done0, a0, b0, c0}, want);
            end
            if (ph == 8) begin
                model(ftab0, 8, et, ec, ei);
                checks++;
                if ({tab0, mc0, fi0, pass0} !== {et, 4'(ec), ei, (ec == 0)}) begin
                    errors++;
                    $display("FAIL b2b result cycle %0d got %h want %h", n, {tab0, mc0, fi0, pass0}, {et, 4'(ec), ei, (ec == 0)});
                end
                ftab0 = (n >= 17) ? 8'($urandom) : gate_truth();
            end
            tick();
        end
        start0 = 1'b0;
        abort0 = 1'b1;
        tick();
        abort0 = 1'b0;
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b final_abort busy got %b want 0", busy0);
        end
    endtask

    task automatic test_async_reset();
        ftab1  = gate_truth();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if ({busy1, tab1} !== {1'b1, 8'h05}) begin
            errors++;
            $display("FAIL pre_reset cycle7 got %h want %h", {busy1, tab1}, {1'b1, 8'h05});
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({a1, b1, c1, busy1, done1, pass1, tab1, mc1, fi1} !== 21'd0) begin
            errors++;
            $display("FAIL async_reset got %h want 0", {a1, b1, c1, busy1, done1, pass1, tab1, mc1, fi1});
        end
        tick();
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({busy1, done1, a1, b1, c1, tab1} !== 13'd0) begin
                errors++;
                $display("FAIL no_activity_after_reset got %h want 0", {busy1, done1, a1, b1, c1, tab1});
            end
        end
        sweep1(gate_truth(), "after_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        sweep1(gate_truth(), "gate");
        sweep1(8'h00, "stuck0");
        sweep1(not_c_truth(), "not_c");
        for (int r = 0; r < 6; r++) sweep1(8'($urandom), "random");
        test_abort(5, gate_truth(), "abort5");
        sweep1(gate_truth(), "after_abort");
        for (int r = 0; r < 3; r++) test_abort(int'($urandom_range(0, 15)), 8'($urandom), "abort_rand");
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
